// File: rtl/rx_word_packer_pkg.sv
// Shared types and width helpers for the UART Rx word packer.
package rx_word_packer_pkg;

  typedef enum logic {
    LOW_WAIT  = 1'b0,
    HIGH_WAIT = 1'b1
  } pk_state_e;

  // Smallest r with 2**r >= n.
  function automatic int log2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rx_word_packer_fifo.sv
// First-word-fall-through FIFO: head is a combinational read of mem[rd_ptr].
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module rx_word_packer_fifo
  import rx_word_packer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int CW   = log2_ceil(DEPTH + 1),
  localparam int PW   = log2_ceil(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Explicit wrap keeps non-power-of-two depths in range.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    if (do_push) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/rx_word_packer.sv
// Pairs UART Rx byte strobes low-byte-first into words, queues them in a FWFT FIFO,
// drops a lone low byte after TIMEOUT idle cycles, and flags FIFO overflow.
module rx_word_packer
  import rx_word_packer_pkg::*;
#(
  parameter int  BITS    = 8,
  parameter int  DEPTH   = 8,
  parameter int  TIMEOUT = 34720,
  localparam int CW      = log2_ceil(DEPTH + 1),
  localparam int TW      = log2_ceil(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              byte_valid,
  input  logic [BITS-1:0]   byte_data,
  input  logic              word_ready,
  input  logic              clr_overflow,
  output logic              word_valid,
  output logic [2*BITS-1:0] word_data,
  output logic [CW-1:0]     count,
  output logic              overflow,
  output logic              frame_err
);

  pk_state_e       state_q, state_d;
  logic [BITS-1:0] low_q, low_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            overflow_q, overflow_d;
  logic            frame_err_q, frame_err_d;
  logic            push, pop, fifo_full, fifo_empty;

  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    timer_d     = timer_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      LOW_WAIT: begin
        if (byte_valid) begin
          low_d   = byte_data;
          timer_d = '0;
          state_d = HIGH_WAIT;
        end
      end
      HIGH_WAIT: begin
        // A high byte on the timeout cycle still completes the word.
        if (byte_valid) begin
          push    = 1'b1;
          state_d = LOW_WAIT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          frame_err_d = 1'b1;
          state_d     = LOW_WAIT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    endcase
  end

  assign pop = !fifo_empty && word_ready;

  always_comb begin
    overflow_d = overflow_q;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    else if (clr_overflow)         overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LOW_WAIT;
      low_q       <= '0;
      timer_q     <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      low_q       <= low_d;
      timer_q     <= timer_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  rx_word_packer_fifo #(
    .WIDTH (2 * BITS),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_dat_i ({byte_data, low_q}),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (count),
    .head_o     (word_data)
  );

  assign word_valid = !fifo_empty;
  assign overflow   = overflow_q;
  assign frame_err  = frame_err_q;

endmodule
